alu_sat_stage: RTL and testbench
================================

# alu_sat_stage

Output stage directly downstream of the `addSub` ALU unit. It selects the add or subtract result, saturates it to the signed LEN-bit range when the unit flags overflow, and buffers results in a 2-entry valid/ready FIFO so the PE write-back path can stall without losing ALU results. It also keeps a saturating count of overflow events for debug and readback.

## Interface
- `LEN`, default 9: datapath width; must match the `addSub` instance.
- `CNT_W`, default 16: width of the overflow event counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rstn`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  an ALU result is present this cycle.
- `in_ready`  out  1  the stage can accept a beat this cycle.
- `op`  in  1  operation select: 0 = add, 1 = subtract.
- `in1_sign`  in  1  MSB of the `addSub` operand in1; sets the saturation direction.
- `add_res`  in  LEN  `addSub` outAdd.
- `sub_res`  in  LEN  `addSub` outSub.
- `ovf_add`  in  1  `addSub` overflowA.
- `ovf_sub`  in  1  `addSub` overflowS.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  the consumer accepts the head entry.
- `out_data`  out  LEN  head result, two's complement.
- `out_ovf`  out  1  the head result overflowed.
- `ovf_count`  out  CNT_W  number of accepted overflow beats.
- `clr_count`  in  1  synchronous clear of `ovf_count`.

## Operation
- **Accept.** A beat is accepted on a rising edge when `in_valid && in_ready`.
- **Select.** The stage computes `sel = op ? sub_res : add_res` and `ovf = op ? ovf_sub : ovf_add`.
- **Saturate.** When `ovf` is 1:
  - `in1_sign` = 0 gives +max (`{1'b0, {LEN-1{1'b1}}}`).
  - `in1_sign` = 1 gives -min (`{1'b1, {LEN-1{1'b0}}}`).
  - When `ovf` is 0, `sel` passes through unchanged.
- **Store.** The stored entry is {data, ovf}. `out_ovf` reports the raw `ovf`, regardless of the saturation setting.
- **FIFO.** 2 entries, with read/write pointers and a 2-bit occupancy count (0..2).
  - `in_ready = (count != 2)`, a combinational decode of the registered count.
  - `out_valid = (count != 0)`.
  - `out_data` and `out_ovf` come from the head entry and are held stable while `out_valid && !out_ready`.
- **Push and pop together.**
  - count 1: count stays 1, and the new entry becomes the head on the next cycle.
  - count 2: `in_ready` = 0, so only the pop occurs.
  - count 0: only the push is possible; the same beat cannot pass through in the same cycle.
- **Pointer wrap.** Pointers are 1 bit and wrap naturally.
- **Overflow counter.** `ovf_count` increments on each accepted beat with `ovf` = 1 and saturates at all-ones.
  - If `clr_count` is asserted in the same cycle as an increment, the clear wins and the counter becomes 0.
  - Counting is independent of downstream stalls.
- **Reset.** Asserting `rstn` low at any time, including mid-transfer, immediately clears:
  - the count and both pointers, so `out_valid` = 0 and `in_ready` = 1;
  - `out_data` = 0 and `out_ovf` = 0;
  - `ovf_count` = 0.
  - In-flight entries are discarded.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is visible on `out_data` with `out_valid` = 1 after edge N (cycle N+1) when the FIFO was empty.
- Throughput is 1 beat per cycle when `out_ready` is held at 1.
- With `out_ready` = 0, two beats are absorbed and `in_ready` falls after the second accepting edge.
- After a pop from a full FIFO, `in_ready` rises in the following cycle. No combinational path exists from `out_ready` to `in_ready`.
- `ovf_count` updates on the edge that accepts the beat.

## Configuration
- Macro `ALU_SAT_STAGE_SATURATE_EN`:
  - Defined: overflowed results are clamped to +max or -min as described above.
  - Undefined: the saturation mux is removed and `sel` is stored wrapped. `out_ovf` and `ovf_count` behave identically in both cases.

## Test plan
All scenarios use LEN = 9.
1. **Reset.** Hold `rstn` = 0 -> `out_valid` = 0, `in_ready` = 1, `out_data` = 0, `ovf_count` = 0.
2. **Plain add.** op=0, `add_res` = 188 (0x0BC), `ovf_add` = 0, `out_ready` = 1 -> next cycle `out_data` = 0x0BC, `out_ovf` = 0, `ovf_count` = 0.
3. **Positive overflow.** op=0, 200+100 (`add_res` = 0x12C, `ovf_add` = 1, `in1_sign` = 0) -> `out_data` = 0x0FF with the macro defined, 0x12C without it; `out_ovf` = 1; `ovf_count` = 1.
4. **Negative overflow.** op=1, -200-100 (`sub_res` = 0x0D4, `ovf_sub` = 1, `in1_sign` = 1) -> `out_data` = 0x100, `out_ovf` = 1.
5. **Backpressure.** Hold `out_ready` = 0 and push 10, 20, 30 -> 10 and 20 are accepted, `in_ready` = 0 after the second edge, and `out_data` holds 10. Then release `out_ready` -> outputs 10, 20, 30 in order with no loss or duplication.
6. **Counter clear and reset mid-transfer.** Assert `clr_count` in the same cycle as an overflow beat -> `ovf_count` = 0. Drop `rstn` while count = 2 -> FIFO empties immediately, and the first post-reset beat appears alone.

Source files
------------

// File: rtl/alu_sat_stage.sv
// Output stage after the addSub ALU: selects add/sub result, optionally saturates on overflow,
// buffers {data, ovf} in a 2-entry valid/ready FIFO and counts overflow beats.
// Saturation is compiled in only when ALU_SAT_STAGE_SATURATE_EN is defined.
module alu_sat_stage #(
   parameter int LEN   = 9,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             op,
   input  logic             in1_sign,
   input  logic [LEN-1:0]   add_res,
   input  logic [LEN-1:0]   sub_res,
   input  logic             ovf_add,
   input  logic             ovf_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [LEN-1:0]   out_data,
   output logic             out_ovf,
   output logic [CNT_W-1:0] ovf_count,
   input  logic             clr_count
);

   logic [LEN-1:0]   sel;
   logic             ovf_in;
   logic [LEN-1:0]   data_in;
   logic             push;
   logic             pop;

   logic [1:0]       count_q, count_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [LEN-1:0]   mem_data_q [2];
   logic [LEN-1:0]   mem_data_d [2];
   logic             mem_ovf_q [2];
   logic             mem_ovf_d [2];
   logic [CNT_W-1:0] ovf_count_q, ovf_count_d;

   always_comb begin
      sel    = op ? sub_res : add_res;
      ovf_in = op ? ovf_sub : ovf_add;
   end

`ifdef ALU_SAT_STAGE_SATURATE_EN
   // in1_sign tells which way the true result ran off the range
   always_comb begin
      data_in = sel;
      if (ovf_in) begin
         data_in = in1_sign ? {1'b1, {(LEN-1){1'b0}}} : {1'b0, {(LEN-1){1'b1}}};
      end
   end
`else
   logic unused_sat_sign;
   assign unused_sat_sign = in1_sign;
   assign data_in = sel;
`endif

   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   assign out_data  = mem_data_q[rd_ptr_q];
   assign out_ovf   = mem_ovf_q[rd_ptr_q];
   assign ovf_count = ovf_count_q;

   always_comb begin
      count_d      = count_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      mem_data_d   = mem_data_q;
      mem_ovf_d    = mem_ovf_q;
      if (push) begin
         mem_data_d[wr_ptr_q] = data_in;
         mem_ovf_d[wr_ptr_q]  = ovf_in;
         wr_ptr_d             = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
         count_d = count_q + 2'd1;
      end else if (pop && !push) begin
         count_d = count_q - 2'd1;
      end
   end

   // clear takes priority over a coincident overflow beat
   always_comb begin
      ovf_count_d = ovf_count_q;
      if (clr_count) begin
         ovf_count_d = '0;
      end else if (push && ovf_in && !(&ovf_count_q)) begin
         ovf_count_d = ovf_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_q       <= 2'd0;
         wr_ptr_q      <= 1'b0;
         rd_ptr_q      <= 1'b0;
         mem_data_q[0] <= '0;
         mem_data_q[1] <= '0;
         mem_ovf_q[0]  <= 1'b0;
         mem_ovf_q[1]  <= 1'b0;
         ovf_count_q   <= '0;
      end else begin
         count_q     <= count_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         mem_data_q  <= mem_data_d;
         mem_ovf_q   <= mem_ovf_d;
         ovf_count_q <= ovf_count_d;
      end
   end

endmodule

// File: tb/tb_alu_sat_stage.sv
// Directed bench for alu_sat_stage (LEN=9, small counter width so counter saturation is reachable).
// Expected data follows ALU_SAT_STAGE_SATURATE_EN when it is defined for the build.
module tb_alu_sat_stage;
   localparam int LEN = 9;
   localparam int CW  = 4;

   logic            clk;
   logic            rstn;
   logic            in_valid;
   logic            in_ready;
   logic            op;
   logic            in1_sign;
   logic [LEN-1:0]  add_res;
   logic [LEN-1:0]  sub_res;
   logic            ovf_add;
   logic            ovf_sub;
   logic            out_valid;
   logic            out_ready;
   logic [LEN-1:0]  out_data;
   logic            out_ovf;
   logic [CW-1:0]   ovf_count;
   logic            clr_count;

   int errors = 0;
   int checks = 0;
   int exp_cnt = 0;

   typedef struct {
      logic           op;
      logic           s;
      logic [LEN-1:0] a;
      logic [LEN-1:0] b;
      logic           oa;
      logic           os;
      logic [LEN-1:0] e_sat;
      logic [LEN-1:0] e_wrap;
      logic           e_ovf;
   } vec_t;

   vec_t vecs [6];

   alu_sat_stage #(.LEN(LEN), .CNT_W(CW)) dut (
      .clk(clk), .rstn(rstn),
      .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .in1_sign(in1_sign),
      .add_res(add_res), .sub_res(sub_res),
      .ovf_add(ovf_add), .ovf_sub(ovf_sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_ovf(out_ovf),
      .ovf_count(ovf_count), .clr_count(clr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic o, input logic s, input logic [LEN-1:0] a,
                        input logic [LEN-1:0] b, input logic oa, input logic os);
      in_valid = 1'b1;
      op       = o;
      in1_sign = s;
      add_res  = a;
      sub_res  = b;
      ovf_add  = oa;
      ovf_sub  = os;
   endtask

   function automatic logic [LEN-1:0] pick(input logic [LEN-1:0] sat, input logic [LEN-1:0] wrap);
`ifdef ALU_SAT_STAGE_SATURATE_EN
      return sat;
`else
      return wrap;
`endif
   endfunction

   initial begin
      vecs[0] = '{1'b0, 1'b0, 9'h0BC, 9'h000, 1'b0, 1'b0, 9'h0BC, 9'h0BC, 1'b0};
      vecs[1] = '{1'b0, 1'b0, 9'h12C, 9'h000, 1'b1, 1'b0, 9'h0FF, 9'h12C, 1'b1};
      vecs[2] = '{1'b1, 1'b1, 9'h000, 9'h0D4, 1'b0, 1'b1, 9'h100, 9'h0D4, 1'b1};
      vecs[3] = '{1'b1, 1'b0, 9'h055, 9'h1F6, 1'b1, 1'b0, 9'h1F6, 9'h1F6, 1'b0};
      vecs[4] = '{1'b0, 1'b1, 9'h033, 9'h1AA, 1'b0, 1'b1, 9'h033, 9'h033, 1'b0};
      vecs[5] = '{1'b0, 1'b1, 9'h0A0, 9'h000, 1'b1, 1'b0, 9'h100, 9'h0A0, 1'b1};

      rstn = 1'b0; in_valid = 1'b1; op = 1'b0; in1_sign = 1'b0;
      add_res = 9'h1AB; sub_res = 9'h0CD; ovf_add = 1'b1; ovf_sub = 1'b1;
      out_ready = 1'b1; clr_count = 1'b0;
      step(); step();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_ovf", out_ovf, 0);
      chk("rst_ovf_count", ovf_count, 0);
      in_valid = 1'b0;
      rstn = 1'b1;
      step();

      // table: streaming with out_ready high, one result per cycle
      for (int i = 0; i < 6; i++) begin
         drive(vecs[i].op, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].oa, vecs[i].os);
         if (vecs[i].e_ovf) exp_cnt++;
         step();
         chk($sformatf("vec%0d_valid", i), out_valid, 1);
         chk($sformatf("vec%0d_data", i), out_data, pick(vecs[i].e_sat, vecs[i].e_wrap));
         chk($sformatf("vec%0d_ovf", i), out_ovf, vecs[i].e_ovf);
         chk($sformatf("vec%0d_count", i), ovf_count, exp_cnt);
      end
      in_valid = 1'b0;
      step();
      chk("drain_valid", out_valid, 0);

      // backpressure: 10 and 20 absorbed, 30 waits
      out_ready = 1'b0;
      drive(1'b0, 1'b0, 9'd10, 9'd0, 1'b0, 1'b0);
      step();
      chk("bp1_valid", out_valid, 1);
      chk("bp1_data", out_data, 10);
      chk("bp1_ready", in_ready, 1);
      drive(1'b0, 1'b0, 9'd20, 9'd0, 1'b0, 1'b0);
      step();
      chk("bp2_ready", in_ready, 0);
      chk("bp2_data", out_data, 10);
      drive(1'b0, 1'b0, 9'd30, 9'd0, 1'b0, 1'b0);
      step();
      chk("bp3_ready", in_ready, 0);
      chk("bp3_hold", out_data, 10);
      out_ready = 1'b1;
      step();
      chk("bp_rel1_data", out_data, 20);
      chk("bp_rel1_ready", in_ready, 1);
      step();
      chk("bp_rel2_data", out_data, 30);
      in_valid = 1'b0;
      step();
      chk("bp_rel3_valid", out_valid, 0);

      // clear wins over a coincident overflow beat
      drive(1'b0, 1'b0, 9'h12C, 9'h000, 1'b1, 1'b0);
      clr_count = 1'b1;
      step();
      exp_cnt = 0;
      chk("clr_count", ovf_count, exp_cnt);
      chk("clr_beat_ovf", out_ovf, 1);
      clr_count = 1'b0;
      // counting continues while stalled; counter saturates at all-ones
      out_ready = 1'b0;
      drive(1'b0, 1'b0, 9'h12C, 9'h000, 1'b1, 1'b0);
      step();
      exp_cnt++;
      chk("cnt_after_clr", ovf_count, exp_cnt);
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step();
         if (exp_cnt < (1 << CW) - 1) exp_cnt++;
      end
      chk("cnt_saturate", ovf_count, exp_cnt);
      chk("cnt_sat_ones", ovf_count, (1 << CW) - 1);
      in_valid = 1'b0;
      step(); step();

      // reset while full
      out_ready = 1'b0;
      drive(1'b0, 1'b0, 9'h011, 9'h000, 1'b1, 1'b0);
      step();
      drive(1'b0, 1'b0, 9'h022, 9'h000, 1'b0, 1'b0);
      step();
      in_valid = 1'b0;
      chk("pre_rst_full", in_ready, 0);
      #2 rstn = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_ready", in_ready, 1);
      chk("mid_rst_data", out_data, 0);
      chk("mid_rst_ovf", out_ovf, 0);
      chk("mid_rst_count", ovf_count, 0);
      step();
      rstn = 1'b1;
      out_ready = 1'b1;
      drive(1'b0, 1'b0, 9'h077, 9'h000, 1'b0, 1'b0);
      step();
      in_valid = 1'b0;
      chk("post_rst_valid", out_valid, 1);
      chk("post_rst_data", out_data, 9'h077);
      step();
      chk("post_rst_alone", out_valid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
